// File: rtl/fifo_prog_sync_if.sv
// fifo_prog_sync_if: write/read handshake, thresholds and status bundle for fifo_prog_sync
interface fifo_prog_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);
  logic                  wr_en;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic [AW:0]           af_thresh;
  logic [AW:0]           ae_thresh;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_en, rd_en, err_clr, din, af_thresh, ae_thresh,
    input  dout, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  wr_en, rd_en, err_clr, din, af_thresh, ae_thresh,
    output dout, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_prog_sync.sv
// fifo_prog_sync: synchronous FIFO with programmable almost flags; sticky error flags when FIFO_ERR_FLAGS_EN is defined
module fifo_prog_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0
) (
  input logic             clk,
  input logic             rst_n,
  fifo_prog_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cnt;
  logic wr_acc, rd_acc;
  // Extra pointer bit distinguishes full from empty; occupancy is the modular difference
  assign cnt              = wr_ptr - rd_ptr;
  assign bus.count        = cnt;
  assign bus.full         = cnt == FULL_CNT;
  assign bus.empty        = cnt == '0;
  assign bus.almost_full  = cnt >= bus.af_thresh;
  assign bus.almost_empty = cnt <= bus.ae_thresh;
  assign wr_acc           = bus.wr_en & ~bus.full;
  assign rd_acc           = bus.rd_en & ~bus.empty;
  // Pointer advance on accepted transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.din;
  end
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout = bus.empty ? '0 : mem[rd_ptr[AW-1:0]];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      // Registered read port: head word captured on the popping edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
      end
      assign bus.dout = dout_q;
    end
  endgenerate
`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  // Sticky error flags; a clear request overrides a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= bus.err_clr ? 1'b0 : ovf_q | (bus.wr_en & bus.full);
      unf_q <= bus.err_clr ? 1'b0 : unf_q | (bus.rd_en & bus.empty);
    end
  end
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_prog_sync.sv
// tb_fifo_prog_sync: directed plus random stimulus on registered-read and FWFT instances against a queue model
module tb_fifo_prog_sync;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW:0] af_t = 4'd6, ae_t = 4'd2;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit m_ov = 1'b0, m_un = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  fifo_prog_sync_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b0 ();
  fifo_prog_sync_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b1 ();
  fifo_prog_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  fifo_prog_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  assign b0.wr_en = wr_en;
  assign b0.rd_en = rd_en;
  assign b0.err_clr = err_clr;
  assign b0.din = din;
  assign b0.af_thresh = af_t;
  assign b0.ae_thresh = ae_t;
  assign b1.wr_en = wr_en;
  assign b1.rd_en = rd_en;
  assign b1.err_clr = err_clr;
  assign b1.din = din;
  assign b1.af_thresh = af_t;
  assign b1.ae_thresh = ae_t;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(b0.count), n);
    chk("count_fwft", 32'(b1.count), n);
    chk("full", 32'(b0.full), 32'(n == DEPTH));
    chk("empty", 32'(b0.empty), 32'(n == 0));
    chk("almost_full", 32'(b0.almost_full), 32'(n >= int'(af_t)));
    chk("almost_empty", 32'(b0.almost_empty), 32'(n <= int'(ae_t)));
    chk("full_fwft", 32'(b1.full), 32'(n == DEPTH));
    chk("dout_reg", 32'(b0.dout), 32'(m_dout));
    if (n > 0) chk("dout_fwft", 32'(b1.dout), 32'(q[0]));
    chk("overflow", 32'(b0.overflow), 32'(ERR_EN & m_ov));
    chk("underflow", 32'(b0.underflow), 32'(ERR_EN & m_un));
  endtask
  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din = d;
    err_clr = clr;
    #1 check_all();
    was_full = q.size() == DEPTH;
    was_empty = q.size() == 0;
    m_ov = clr ? 1'b0 : (m_ov | (w & was_full));
    m_un = clr ? 1'b0 : (m_un | (r & was_empty));
    if (r && !was_empty) m_dout = q.pop_front();
    if (w && !was_full) q.push_back(d);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_dout = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    cyc(1'b1, 1'b0, 8'h09, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'hA5, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      af_t = (AW+1)'($urandom_range(0, 9));
      ae_t = (AW+1)'($urandom_range(0, 9));
      cyc($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35),
          $urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70),
          DW'($urandom), $urandom_range(0, 19) == 0);
      if (i == 200) pulse_reset();
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_prog_sync.md
FIFO_PROG_SYNC -- requirements
Module: fifo_prog_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of storage entries (power of 2, >=4); AW = log2(DEPTH).
REQ-003 SHALL have parameter FWFT, default 0, meaning read mode (0 = registered read, 1 = first-word-fall-through).
REQ-004 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  meaning write request.
REQ-007 SHALL have port din  input  DATA_WIDTH  meaning write data.
REQ-008 SHALL have port rd_en  input  1  meaning read/pop request.
REQ-009 SHALL have port dout  output  DATA_WIDTH  meaning read data.
REQ-010 SHALL have port af_thresh  input  AW+1  meaning almost-full threshold in entries.
REQ-011 SHALL have port ae_thresh  input  AW+1  meaning almost-empty threshold in entries.
REQ-012 SHALL have port err_clr  input  1  meaning clears sticky error flags.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  meaning status flags.
REQ-014 SHALL have port count  output  AW+1  meaning current occupancy 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  meaning sticky error flags.

Function
REQ-016 SHALL keep AW+1-bit write/read pointers; count = wr_ptr - rd_ptr modulo 2^(AW+1); memory index = low AW bits.
REQ-017 SHALL use all DEPTH entries: full = (count == DEPTH), empty = (count == 0).
REQ-018 SHALL accept a write iff wr_en && !full, storing din at wr_ptr and incrementing wr_ptr on that edge.
REQ-019 SHALL accept a read iff rd_en && !empty, incrementing rd_ptr on that edge; full/empty evaluated from pre-edge state.
REQ-020 SHALL, on simultaneous accepted write and read, leave count unchanged; when empty only the write occurs, when full only the read occurs.
REQ-021 SHALL, with FWFT=0, load dout with the head word one cycle after an accepted read, and hold dout otherwise.
REQ-022 SHALL, with FWFT=1, present the head word on dout whenever !empty with zero latency; an accepted read exposes the next word after the edge; dout is don't-care while empty.
REQ-023 SHALL drive almost_full = (count >= af_thresh) and almost_empty = (count <= ae_thresh), combinationally from registered count.
REQ-024 SHALL wrap pointers silently through 2^(AW+1) with no effect on count or flags.
REQ-025 SHALL ignore rd_en when empty and wr_en when full, beyond error flagging.

Reset
REQ-026 SHALL on rst_n low asynchronously clear pointers, count=0, dout=0, overflow=0, underflow=0; empty=1, full=0, almost_empty=1 (ae_thresh>=0), almost_full=(af_thresh==0).
REQ-027 SHALL discard all stored data on reset mid-operation; memory contents need no reset.

Configuration
REQ-028 SHALL, when FIFO_ERR_FLAGS_EN is defined, set overflow on any cycle with wr_en && full and underflow on wr_en-independent rd_en && empty, both sticky until err_clr (err_clr wins over a same-cycle set).
REQ-029 SHALL, when FIFO_ERR_FLAGS_EN is undefined, tie overflow and underflow to 0, ignore err_clr, and instantiate no error logic.

Verification
REQ-030 SHALL cover: DEPTH=8, FWFT=0, write 0x01..0x08 -> full=1 and count=8 after 8th edge; reads return 0x01..0x08 each one cycle after rd_en; empty=1 after 8th read.
REQ-031 SHALL cover: FWFT=1, write 0xA5 to empty FIFO -> dout=0xA5 the cycle after the write edge with no rd_en; rd_en pops it, empty=1.
REQ-032 SHALL cover: count=8 (full), wr_en=rd_en=1 with din=0x55 -> read accepted, write dropped, count=7; with FIFO_ERR_FLAGS_EN, overflow=1 until err_clr pulse.
REQ-033 SHALL cover: count=3, wr_en=rd_en=1 for 20 cycles -> count stays 3, pointers wrap past 15, data order preserved.
REQ-034 SHALL cover: af_thresh=6, ae_thresh=2, fill 0->8 -> almost_empty high for count 0..2, almost_full high for count 6..8.
REQ-035 SHALL cover: rst_n low for one cycle at count=5 -> count=0, empty=1, dout=0, overflow=underflow=0 immediately, without waiting for a clock edge.
